game_round_ctrl: RTL and testbench

Parametrised match controller: the successor to the single-round game FSM. It owns the start/countdown/play/pause/round-end/win/lose state machine, per-side HP with invulnerability frames, and best-of-N round scoring. It sits between the player/enemy/bullet blocks, which supply hit and shield flags, and the renderer, which consumes state, HP, round scores and countdown.

---
 rtl/game_round_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_game_round_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_round_ctrl.sv
// Best-of-N match controller: round state machine, per-side HP with
// invulnerability frames, countdown/hold timers and round scoring.
module game_round_ctrl #(
    parameter int unsigned HP_W            = 3,
    parameter int unsigned MAX_HP          = 5,
    parameter int unsigned IFRAME_TICKS    = 30,
    parameter int unsigned COUNTDOWN_TICKS = 180,
    parameter int unsigned ROUND_END_TICKS = 120,
    parameter int unsigned ROUNDS_TO_WIN   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tick,
    input  logic            select,
    input  logic            pause,
    input  logic            player_hit,
    input  logic            enemy_hit,
    input  logic            player_shield,
    input  logic            enemy_shield,
    output logic [2:0]      o_state,
    output logic [HP_W-1:0] o_player_hp,
    output logic [HP_W-1:0] o_enemy_hp,
    output logic [2:0]      o_player_rounds,
    output logic [2:0]      o_enemy_rounds,
    output logic            o_player_inv,
    output logic            o_enemy_inv,
    output logic [7:0]      o_countdown,
    output logic            o_round_reset
);

    localparam int unsigned INV_W  = $clog2(IFRAME_TICKS + 1);
    localparam int unsigned HOLD_W = $clog2(ROUND_END_TICKS + 1);
    localparam int unsigned CD_W   = 8;
    localparam int unsigned RND_W  = 3;

    typedef enum logic [2:0] {
        S_START     = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAY      = 3'd2,
        S_PAUSED    = 3'd3,
        S_ROUND_END = 3'd4,
        S_WIN       = 3'd5,
        S_LOSE      = 3'd6
    } state_e;

    state_e             state_q, state_d;
    logic [CD_W-1:0]    countdown_q, countdown_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [HP_W-1:0]    p_hp_q, p_hp_d, e_hp_q, e_hp_d;
    logic [RND_W-1:0]   p_rnd_q, p_rnd_d, e_rnd_q, e_rnd_d;
    logic [INV_W-1:0]   p_inv_cnt_q, p_inv_cnt_d, e_inv_cnt_q, e_inv_cnt_d;
    logic               p_inv_q, p_inv_d, e_inv_q, e_inv_d;
    logic               round_reset_q, round_reset_d;
    logic               p_dmg_c, e_dmg_c;

    assign p_dmg_c = player_hit && !player_shield && (p_inv_cnt_q == '0);
    assign e_dmg_c = enemy_hit  && !enemy_shield  && (e_inv_cnt_q == '0);

    // Next-state, timers, HP and scoring
    always_comb begin
        state_d       = state_q;
        countdown_d   = countdown_q;
        hold_d        = hold_q;
        p_hp_d        = p_hp_q;
        e_hp_d        = e_hp_q;
        p_rnd_d       = p_rnd_q;
        e_rnd_d       = e_rnd_q;
        p_inv_cnt_d   = p_inv_cnt_q;
        e_inv_cnt_d   = e_inv_cnt_q;
        round_reset_d = 1'b0;

        unique case (state_q)
            S_START: begin
                if (select) begin
                    state_d       = S_COUNTDOWN;
                    countdown_d   = CD_W'(COUNTDOWN_TICKS);
                    p_hp_d        = HP_W'(MAX_HP);
                    e_hp_d        = HP_W'(MAX_HP);
                    p_rnd_d       = '0;
                    e_rnd_d       = '0;
                    p_inv_cnt_d   = '0;
                    e_inv_cnt_d   = '0;
                    round_reset_d = 1'b1;
                end
            end
            S_COUNTDOWN: begin
                if (tick) begin
                    if (countdown_q == CD_W'(1)) begin
                        state_d     = S_PLAY;
                        countdown_d = '0;
                    end else begin
                        countdown_d = countdown_q - CD_W'(1);
                    end
                end
            end
            S_PLAY: begin
                if (tick && (p_inv_cnt_q != '0)) p_inv_cnt_d = p_inv_cnt_q - INV_W'(1);
                if (tick && (e_inv_cnt_q != '0)) e_inv_cnt_d = e_inv_cnt_q - INV_W'(1);
                if (p_dmg_c) begin
                    if (p_hp_q != '0) p_hp_d = p_hp_q - HP_W'(1);
                    p_inv_cnt_d = INV_W'(IFRAME_TICKS);
                end
                if (e_dmg_c) begin
                    if (e_hp_q != '0) e_hp_d = e_hp_q - HP_W'(1);
                    e_inv_cnt_d = INV_W'(IFRAME_TICKS);
                end
                // Round end is judged on registered HP and overrides pause
                if ((p_hp_q == '0) || (e_hp_q == '0)) begin
                    state_d = S_ROUND_END;
                    hold_d  = HOLD_W'(ROUND_END_TICKS);
                    if ((p_hp_q == '0) && (e_hp_q != '0)) e_rnd_d = e_rnd_q + RND_W'(1);
                    if ((e_hp_q == '0) && (p_hp_q != '0)) p_rnd_d = p_rnd_q + RND_W'(1);
                end else if (pause) begin
                    state_d = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (pause) state_d = S_PLAY;
            end
            S_ROUND_END: begin
                if (tick) begin
                    if (hold_q == HOLD_W'(1)) begin
                        hold_d = '0;
                        if (p_rnd_q == RND_W'(ROUNDS_TO_WIN)) begin
                            state_d = S_WIN;
                        end else if (e_rnd_q == RND_W'(ROUNDS_TO_WIN)) begin
                            state_d = S_LOSE;
                        end else begin
                            state_d       = S_COUNTDOWN;
                            countdown_d   = CD_W'(COUNTDOWN_TICKS);
                            p_hp_d        = HP_W'(MAX_HP);
                            e_hp_d        = HP_W'(MAX_HP);
                            p_inv_cnt_d   = '0;
                            e_inv_cnt_d   = '0;
                            round_reset_d = 1'b1;
                        end
                    end else begin
                        hold_d = hold_q - HOLD_W'(1);
                    end
                end
            end
            S_WIN, S_LOSE: begin
                if (select) state_d = S_START;
            end
            default: state_d = S_START;
        endcase

        p_inv_d = (p_inv_cnt_d != '0);
        e_inv_d = (e_inv_cnt_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_START;
            countdown_q   <= '0;
            hold_q        <= '0;
            p_hp_q        <= HP_W'(MAX_HP);
            e_hp_q        <= HP_W'(MAX_HP);
            p_rnd_q       <= '0;
            e_rnd_q       <= '0;
            p_inv_cnt_q   <= '0;
            e_inv_cnt_q   <= '0;
            p_inv_q       <= 1'b0;
            e_inv_q       <= 1'b0;
            round_reset_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            countdown_q   <= countdown_d;
            hold_q        <= hold_d;
            p_hp_q        <= p_hp_d;
            e_hp_q        <= e_hp_d;
            p_rnd_q       <= p_rnd_d;
            e_rnd_q       <= e_rnd_d;
            p_inv_cnt_q   <= p_inv_cnt_d;
            e_inv_cnt_q   <= e_inv_cnt_d;
            p_inv_q       <= p_inv_d;
            e_inv_q       <= e_inv_d;
            round_reset_q <= round_reset_d;
        end
    end

    assign o_state         = state_q;
    assign o_player_hp     = p_hp_q;
    assign o_enemy_hp      = e_hp_q;
    assign o_player_rounds = p_rnd_q;
    assign o_enemy_rounds  = e_rnd_q;
    assign o_player_inv    = p_inv_q;
    assign o_enemy_inv     = e_inv_q;
    assign o_countdown     = countdown_q;
    assign o_round_reset   = round_reset_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl at default parameters: countdown, iframes,
// shields, pause freeze, draw, match win/lose and async reset mid-play.
module tb_game_round_ctrl;

    logic       clk;
    logic       rst_n;
    logic       tick, select, pause;
    logic       player_hit, enemy_hit, player_shield, enemy_shield;
    logic [2:0] o_state;
    logic [2:0] o_player_hp, o_enemy_hp;
    logic [2:0] o_player_rounds, o_enemy_rounds;
    logic       o_player_inv, o_enemy_inv;
    logic [7:0] o_countdown;
    logic       o_round_reset;

    int vectors;
    int miscompares;

    game_round_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .tick            (tick),
        .select          (select),
        .pause           (pause),
        .player_hit      (player_hit),
        .enemy_hit       (enemy_hit),
        .player_shield   (player_shield),
        .enemy_shield    (enemy_shield),
        .o_state         (o_state),
        .o_player_hp     (o_player_hp),
        .o_enemy_hp      (o_enemy_hp),
        .o_player_rounds (o_player_rounds),
        .o_enemy_rounds  (o_enemy_rounds),
        .o_player_inv    (o_player_inv),
        .o_enemy_inv     (o_enemy_inv),
        .o_countdown     (o_countdown),
        .o_round_reset   (o_round_reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: inputs set before the call are sampled, pulses then drop
    task automatic cyc();
        @(posedge clk);
        #1;
        tick       = 1'b0;
        select     = 1'b0;
        pause      = 1'b0;
        player_hit = 1'b0;
        enemy_hit  = 1'b0;
    endtask

    // n frame pulses, each preceded by an idle cycle; returns right after the last tick edge
    task automatic ticks(input int n);
        repeat (n) begin
            cyc();
            tick = 1'b1;
            cyc();
        end
    endtask

    // Five damaging hits on the chosen side(s), spaced past the iframe window
    task automatic hit5(input logic pl, input logic en);
        for (int i = 0; i < 5; i++) begin
            player_hit = pl;
            enemy_hit  = en;
            cyc();
            if (i < 4) ticks(30);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        tick = 1'b0; select = 1'b0; pause = 1'b0;
        player_hit = 1'b0; enemy_hit = 1'b0;
        player_shield = 1'b0; enemy_shield = 1'b0;
        cyc();
        cyc();
        chk("rst_state", 32'(o_state), 0);
        chk("rst_php", 32'(o_player_hp), 5);
        chk("rst_ehp", 32'(o_enemy_hp), 5);
        chk("rst_prnd", 32'(o_player_rounds), 0);
        chk("rst_ernd", 32'(o_enemy_rounds), 0);
        chk("rst_pinv", 32'(o_player_inv), 0);
        chk("rst_einv", 32'(o_enemy_inv), 0);
        chk("rst_cd", 32'(o_countdown), 0);
        chk("rst_rr", 32'(o_round_reset), 0);
        rst_n = 1'b1;
        cyc();

        select = 1'b1; cyc();
        chk("sel_state", 32'(o_state), 1);
        chk("sel_cd", 32'(o_countdown), 180);
        chk("sel_rr", 32'(o_round_reset), 1);
        cyc();
        chk("rr_drop", 32'(o_round_reset), 0);
        ticks(179);
        chk("cd_at1", 32'(o_countdown), 1);
        chk("cd_state", 32'(o_state), 1);
        enemy_hit = 1'b1; cyc();
        chk("cd_hit_ign", 32'(o_enemy_hp), 5);
        ticks(1);
        chk("play_state", 32'(o_state), 2);
        chk("play_cd", 32'(o_countdown), 0);

        enemy_hit = 1'b1; cyc();
        chk("hit1_ehp", 32'(o_enemy_hp), 4);
        chk("hit1_einv", 32'(o_enemy_inv), 1);
        ticks(10);
        enemy_hit = 1'b1; cyc();
        chk("iframe_ehp", 32'(o_enemy_hp), 4);
        ticks(19);
        chk("inv_last", 32'(o_enemy_inv), 1);
        ticks(1);
        chk("inv_expire", 32'(o_enemy_inv), 0);

        enemy_shield = 1'b1; enemy_hit = 1'b1; cyc();
        chk("shield_ehp", 32'(o_enemy_hp), 4);
        chk("shield_einv", 32'(o_enemy_inv), 0);
        enemy_shield = 1'b0;

        player_hit = 1'b1; cyc();
        chk("phit_php", 32'(o_player_hp), 4);
        chk("phit_pinv", 32'(o_player_inv), 1);
        pause = 1'b1; cyc();
        chk("paused", 32'(o_state), 3);
        ticks(50);
        chk("pause_inv", 32'(o_player_inv), 1);
        player_hit = 1'b1; enemy_hit = 1'b1; cyc();
        chk("pause_php", 32'(o_player_hp), 4);
        chk("pause_ehp", 32'(o_enemy_hp), 4);
        pause = 1'b1; cyc();
        chk("resume", 32'(o_state), 2);
        ticks(29);
        chk("frozen_inv", 32'(o_player_inv), 1);
        ticks(1);
        chk("frozen_exp", 32'(o_player_inv), 0);

        for (int i = 0; i < 4; i++) begin
            enemy_hit = 1'b1; cyc();
            chk("ko_ehp", 32'(o_enemy_hp), 32'(3 - i));
            if (i < 3) ticks(30);
        end
        chk("ko_lat", 32'(o_state), 2);
        pause = 1'b1; player_hit = 1'b1; cyc();
        chk("ko_state", 32'(o_state), 4);
        chk("ko_prnd", 32'(o_player_rounds), 1);
        chk("ko_ernd", 32'(o_enemy_rounds), 0);
        chk("ko_late_hit", 32'(o_player_hp), 3);
        ticks(119);
        chk("hold_state", 32'(o_state), 4);
        ticks(1);
        chk("r2_state", 32'(o_state), 1);
        chk("r2_php", 32'(o_player_hp), 5);
        chk("r2_ehp", 32'(o_enemy_hp), 5);
        chk("r2_cd", 32'(o_countdown), 180);
        chk("r2_rr", 32'(o_round_reset), 1);
        chk("r2_prnd", 32'(o_player_rounds), 1);

        ticks(180);
        chk("r2_play", 32'(o_state), 2);
        for (int i = 0; i < 4; i++) begin
            player_hit = 1'b1; enemy_hit = 1'b1; cyc();
            ticks(30);
        end
        chk("draw_php1", 32'(o_player_hp), 1);
        chk("draw_ehp1", 32'(o_enemy_hp), 1);
        player_hit = 1'b1; enemy_hit = 1'b1; cyc();
        chk("draw_php0", 32'(o_player_hp), 0);
        chk("draw_ehp0", 32'(o_enemy_hp), 0);
        cyc();
        chk("draw_state", 32'(o_state), 4);
        chk("draw_prnd", 32'(o_player_rounds), 1);
        chk("draw_ernd", 32'(o_enemy_rounds), 0);
        ticks(120);
        chk("draw_next", 32'(o_state), 1);
        chk("draw_php", 32'(o_player_hp), 5);

        ticks(180);
        hit5(1'b0, 1'b1);
        cyc();
        chk("r3_state", 32'(o_state), 4);
        chk("r3_prnd", 32'(o_player_rounds), 2);
        ticks(120);
        chk("win_state", 32'(o_state), 5);
        chk("win_prnd", 32'(o_player_rounds), 2);
        chk("win_ehp", 32'(o_enemy_hp), 0);
        select = 1'b1; cyc();
        chk("win_start", 32'(o_state), 0);
        chk("start_hold", 32'(o_player_rounds), 2);
        select = 1'b1; cyc();
        chk("new_match", 32'(o_state), 1);
        chk("new_prnd", 32'(o_player_rounds), 0);
        chk("new_ehp", 32'(o_enemy_hp), 5);

        ticks(180);
        hit5(1'b1, 1'b0);
        cyc();
        chk("l1_ernd", 32'(o_enemy_rounds), 1);
        ticks(120);
        ticks(180);
        hit5(1'b1, 1'b0);
        cyc();
        ticks(120);
        chk("lose_state", 32'(o_state), 6);
        chk("lose_ernd", 32'(o_enemy_rounds), 2);
        chk("lose_php", 32'(o_player_hp), 0);

        select = 1'b1; cyc();
        select = 1'b1; cyc();
        ticks(180);
        enemy_hit = 1'b1; cyc();
        chk("pre_rst_ehp", 32'(o_enemy_hp), 4);
        chk("pre_rst_st", 32'(o_state), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(o_state), 0);
        chk("arst_ehp", 32'(o_enemy_hp), 5);
        chk("arst_einv", 32'(o_enemy_inv), 0);
        chk("arst_rnd", 32'(o_enemy_rounds), 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
